uart_rx_core: RTL and testbench
===============================

# uart_rx_core

Parametrised, single-clock UART receiver, the successor to the fixed-format receive path. It samples the asynchronous serial `in` line with a programmable oversampling tick. It supports 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. Received words are buffered in an internal FIFO with a valid/ready output handshake, and parity, framing and overrun errors are reported separately. It sits between the board-level RX pin and the downstream character consumer.

## Interface
- `OVERSAMPLE`, 16: ticks per bit; even, ≥ 8.
- `DIV_W`, 16: width of the baud divisor.
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, ≥ 2.
- `WIDTH_DATABITS`, 8: output data width (maximum data bits).
- `WIDTH_ERROR`, 3: error vector `{overrun, framing, parity}`.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial RX line; idle high.
- `cfg_div`  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1.
- `cfg_databits`  in  2  data bits: 00=5, 01=6, 10=7, 11=8.
- `cfg_parity`  in  2  parity: 00 none, 01 even, 10 odd, 11 none.
- `cfg_stop2`  in  1  0 = one stop bit, 1 = two stop bits.
- `out`  out  WIDTH_DATABITS  FIFO head, right-justified, unused MSBs 0.
- `valid_out`  out  1  FIFO not empty.
- `ready_out`  in  1  consumer accepts `out`.
- `error`  out  WIDTH_ERROR  error flags of the last frame; held until the next error pulse.
- `valid_error`  out  1  one-cycle pulse; `error` is valid in this cycle.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- `in` passes through a 2-FF synchroniser (`rs`) before any logic sees it.
- Tick generator: a counter produces a one-cycle `tick` every `max(cfg_div,1)` clk cycles. The counter is free-running and is restarted on start-edge detection.
- Config inputs are latched on start-edge detection. Changes mid-frame have no effect until IDLE.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: a falling edge of `rs` goes to START.
  - START: after OVERSAMPLE/2 ticks, sample. If 1, this is a false start: return to IDLE with no error. If 0, go to DATA.
  - DATA: take one sample every OVERSAMPLE ticks, LSB first, N = latched data bits. Then go to PARITY if parity is enabled, else STOP1.
  - PARITY: parity error if the XOR of data and the parity bit is 1 (even) or 0 (odd).
  - STOP1: framing error if the sample is 0. Go to STOP2 if `cfg_stop2`, else end of frame.
  - STOP2: framing error if the sample is 0. End of frame.
- End of frame (EOF) is the cycle of the final stop sample. The FSM returns to IDLE immediately, so a start edge in the following cycle is detected.
- At EOF:
  - If there is no parity or framing error and the FIFO can accept, the word is pushed.
  - If there is a parity or framing error, the word is discarded.
  - If the word is error-free but the FIFO cannot accept, the overrun flag is set and the word is discarded.
- "Can accept" means not full, or a pop happens in the same cycle.
- FIFO pop happens when `valid_out && ready_out`. Simultaneous push and pop leaves `fifo_level` unchanged. Pop on empty is ignored.

## Timing
- Reset values: `out`=0, `valid_out`=0, `error`=0, `valid_error`=0, `fifo_level`=0. FSM goes to IDLE and the FIFO pointers clear.
- Reset asserted mid-frame aborts the frame, drops any partial word and raises no error.
- The first sample lands at the bit centre: OVERSAMPLE/2 ticks after the start edge (plus 2 cycles of synchroniser delay).
- Push at EOF cycle T gives `valid_out`=1 and `out`=word at T+1.
- `valid_error` pulses at T+1 when any flag is set. The flags may combine, e.g. 3'b011.
- Pop at cycle P presents the next head at P+1.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each bit (start, data, parity, stop) is a 2-of-3 majority vote of samples at ticks OVERSAMPLE/2−1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The decision is taken at tick OVERSAMPLE/2+1, so EOF and all outputs shift one tick later.
- `UART_RX_MAJORITY_EN` undefined: single sample at tick OVERSAMPLE/2.

## Test plan
All scenarios use `cfg_div`=4 and OVERSAMPLE=16, so one bit is 64 clk cycles.
- 8N1 frame carrying 0xA5, `ready_out`=1 → `valid_out` for 1 cycle with `out`=0xA5; `valid_error` never asserts.
- 7E1 frame carrying 0x41 with parity bit 0 → `out`=0x41. Same frame with parity bit 1 → `error`=3'b001 pulse; FIFO stays empty.
- 8N2 frame carrying 0x3C with the second stop bit low → `error`=3'b010; nothing pushed. The next correct frame, 0x3C, is received normally.
- `in` driven low for 8 cycles, then high → no frame, no error; FSM returns to IDLE.
- `ready_out`=0 while sending 9 frames (0x01..0x09) → `fifo_level`=8; the 9th frame gives `error`=3'b100. Draining then yields 0x01..0x08 in order.
- `rst_n` pulsed low after 3 data bits of a frame → all outputs 0. The following frame carrying 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver (5-8 data bits, none/even/odd parity, 1/2 stop bits)
// with a receive FIFO. Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each bit centre.
module uart_rx_core #(
  parameter int OVERSAMPLE     = 16,
  parameter int DIV_W          = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int WIDTH_DATABITS = 8,
  parameter int WIDTH_ERROR    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in,
  input  logic [DIV_W-1:0]              cfg_div,
  input  logic [1:0]                    cfg_databits,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic [WIDTH_DATABITS-1:0]     out,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [WIDTH_ERROR-1:0]        error,
  output logic                          valid_error,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
`ifdef UART_RX_MAJORITY_EN
  localparam logic [SW-1:0] START_LAST = SW'(OVERSAMPLE/2);
`else
  localparam logic [SW-1:0] START_LAST = SW'(OVERSAMPLE/2 - 1);
`endif
  localparam logic [SW-1:0] BIT_LAST = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t r_state, w_next;

  logic [1:0]                r_sync;
  logic                      r_rs_d, w_rs, w_bit, w_tick, w_samp, w_start_edge;
  logic [DIV_W-1:0]          r_tcnt, r_div;
  logic [SW-1:0]             r_scnt;
  logic [2:0]                r_bcnt, w_last;
  logic [1:0]                r_nb;
  logic                      r_par_en, r_par_odd, r_stop2, r_perr, r_ferr;
  logic [WIDTH_DATABITS-1:0] r_data;
  logic                      w_eof, w_ferr, w_push, w_ovr, w_full, w_pop;
  logic [WIDTH_ERROR-1:0]    r_error;
  logic                      r_verr;
  logic [WIDTH_DATABITS-1:0] r_mem [FIFO_DEPTH];
  logic [LW-1:0]             r_wptr, r_rptr;

  assign w_rs         = r_sync[1];
  assign w_start_edge = (r_state == IDLE) && r_rs_d && !w_rs;
  assign w_tick       = (r_tcnt == r_div - DIV_W'(1));
  assign w_samp       = w_tick && (r_scnt == ((r_state == START) ? START_LAST : BIT_LAST));
  assign w_last       = 3'd4 + {1'b0, r_nb};

`ifdef UART_RX_MAJORITY_EN
  // Two previous tick samples plus the current one form the vote.
  logic [1:0] r_smp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      r_smp <= 2'b11;
    else if (w_tick) r_smp <= {r_smp[0], w_rs};
  assign w_bit = (r_smp[1] & r_smp[0]) | (r_smp[1] & w_rs) | (r_smp[0] & w_rs);
`else
  assign w_bit = w_rs;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_next = START;
      START:   if (w_samp) w_next = w_bit ? IDLE : DATA;
      DATA:    if (w_samp && r_bcnt == w_last) w_next = r_par_en ? PARITY : STOP1;
      PARITY:  if (w_samp) w_next = STOP1;
      STOP1:   if (w_samp) w_next = r_stop2 ? STOP2 : IDLE;
      STOP2:   if (w_samp) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_eof  = w_samp && ((r_state == STOP1 && !r_stop2) || r_state == STOP2);
    w_ferr = r_ferr | ~w_bit;
    w_push = w_eof && !r_perr && !w_ferr && (!w_full || w_pop);
    w_ovr  = w_eof && !r_perr && !w_ferr && w_full && !w_pop;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sync <= 2'b11;  r_rs_d <= 1'b1;
      r_tcnt <= '0;     r_div <= DIV_W'(1);
      r_scnt <= '0;     r_bcnt <= '0;    r_nb <= '0;
      r_par_en <= 1'b0; r_par_odd <= 1'b0; r_stop2 <= 1'b0;
      r_perr <= 1'b0;   r_ferr <= 1'b0;  r_data <= '0;
      r_error <= '0;    r_verr <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], in};
      r_rs_d <= w_rs;
      r_verr <= 1'b0;
      if (w_eof && (r_perr || w_ferr || w_ovr)) begin
        r_error <= WIDTH_ERROR'({w_ovr, w_ferr, r_perr});
        r_verr  <= 1'b1;
      end
      if (w_start_edge) begin
        // Restart the bit timing and freeze the frame format for this frame.
        r_tcnt    <= '0;
        r_div     <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
        r_nb      <= cfg_databits;
        r_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        r_par_odd <= (cfg_parity == 2'b10);
        r_stop2   <= cfg_stop2;
        r_scnt <= '0; r_bcnt <= '0; r_data <= '0; r_perr <= 1'b0; r_ferr <= 1'b0;
      end else begin
        r_tcnt <= w_tick ? '0 : r_tcnt + DIV_W'(1);
        if (w_tick) r_scnt <= w_samp ? '0 : r_scnt + SW'(1);
        if (w_samp)
          case (r_state)
            DATA:    begin r_data[r_bcnt] <= w_bit; r_bcnt <= r_bcnt + 3'd1; end
            PARITY:  r_perr <= (^r_data) ^ w_bit ^ r_par_odd;
            STOP1:   r_ferr <= ~w_bit;
            default: ;
          endcase
      end
    end

  assign fifo_level  = r_wptr - r_rptr;
  assign valid_out   = (fifo_level != '0);
  assign w_full      = (fifo_level == LW'(FIFO_DEPTH));
  assign w_pop       = valid_out && ready_out;
  assign out         = valid_out ? r_mem[r_rptr[AW-1:0]] : '0;
  assign error       = r_error;
  assign valid_error = r_verr;

  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr[AW-1:0]] <= r_data;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + LW'(1);
      if (w_pop)  r_rptr <= r_rptr + LW'(1);
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: cfg_div=4, OVERSAMPLE=16 (64 clk per bit).
module tb_uart_rx_core;
  localparam int BIT = 64;

  logic       clk = 1'b0, rst_n = 1'b0, rx = 1'b1, ready_out = 1'b1;
  logic [15:0] cfg_div = 16'd4;
  logic [1:0] cfg_databits = 2'b11, cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic [7:0] dout;
  logic       valid_out, valid_error;
  logic [2:0] error;
  logic [3:0] fifo_level;

  int n_cmp = 0, n_bad = 0, n_pops = 0;
  logic [7:0] exp_data[$];
  logic [2:0] exp_err[$];
  logic [7:0] mon_d;
  logic [2:0] mon_e;

  uart_rx_core dut (
    .clk(clk), .rst_n(rst_n), .in(rx), .cfg_div(cfg_div), .cfg_databits(cfg_databits),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .out(dout), .valid_out(valid_out),
    .ready_out(ready_out), .error(error), .valid_error(valid_error), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Scoreboard: pop expected words/errors as the DUT produces them.
  always @(negedge clk) if (rst_n) begin
    if (valid_out && ready_out) begin
      n_cmp++; n_pops++;
      if (exp_data.size() == 0) begin
        n_bad++; $display("FAIL data_unexpected got %h expected none", dout);
      end else begin
        mon_d = exp_data.pop_front();
        if (dout !== mon_d) begin n_bad++; $display("FAIL data got %h expected %h", dout, mon_d); end
      end
    end
    if (valid_error) begin
      n_cmp++;
      if (exp_err.size() == 0) begin
        n_bad++; $display("FAIL error_unexpected got %b expected none", error);
      end else begin
        mon_e = exp_err.pop_front();
        if (error !== mon_e) begin n_bad++; $display("FAIL error got %b expected %b", error, mon_e); end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input int nb, input bit par_en, input bit par_bit,
                            input bit two_stop, input bit s2val);
    @(negedge clk); rx = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < nb; i++) begin rx = d[i]; repeat (BIT) @(negedge clk); end
    if (par_en) begin rx = par_bit; repeat (BIT) @(negedge clk); end
    rx = 1'b1; repeat (BIT) @(negedge clk);
    if (two_stop) begin rx = s2val; repeat (BIT) @(negedge clk); end
    rx = 1'b1;
  endtask

  task automatic idle_check(input string name, input int lvl);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (exp_data.size() + exp_err.size() !== 0) begin
      n_bad++; $display("FAIL %s_pending got %0d outstanding expected 0", name, exp_data.size() + exp_err.size());
    end
    n_cmp++;
    if (fifo_level !== 4'(lvl)) begin
      n_bad++; $display("FAIL %s_level got %0d expected %0d", name, fifo_level, lvl);
    end
  endtask

  task automatic test_reset;
    repeat (4) @(negedge clk);
    n_cmp += 5;
    if (dout !== 8'h00)        begin n_bad++; $display("FAIL rst_out got %h expected 00", dout); end
    if (valid_out !== 1'b0)    begin n_bad++; $display("FAIL rst_valid_out got %b expected 0", valid_out); end
    if (error !== 3'b000)      begin n_bad++; $display("FAIL rst_error got %b expected 000", error); end
    if (valid_error !== 1'b0)  begin n_bad++; $display("FAIL rst_valid_error got %b expected 0", valid_error); end
    if (fifo_level !== 4'd0)   begin n_bad++; $display("FAIL rst_level got %0d expected 0", fifo_level); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1;
    int p0;
    p0 = n_pops;
    cfg_databits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    exp_data.push_back(8'hA5);
    send_frame(8'hA5, 8, 0, 0, 0, 1);
    idle_check("8n1", 0);
    n_cmp++;
    if (n_pops - p0 !== 1) begin n_bad++; $display("FAIL 8n1_valid_cycles got %0d expected 1", n_pops - p0); end
  endtask

  task automatic test_parity;
    cfg_databits = 2'b10; cfg_parity = 2'b01; cfg_stop2 = 1'b0;
    exp_data.push_back(8'h41);
    send_frame(8'h41, 7, 1, 0, 0, 1);
    idle_check("7e1_ok", 0);
    exp_err.push_back(3'b001);
    send_frame(8'h41, 7, 1, 1, 0, 1);
    idle_check("7e1_bad", 0);
  endtask

  task automatic test_framing;
    cfg_databits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b1;
    exp_err.push_back(3'b010);
    send_frame(8'h3C, 8, 0, 0, 1, 0);
    idle_check("8n2_bad", 0);
    exp_data.push_back(8'h3C);
    send_frame(8'h3C, 8, 0, 0, 1, 1);
    idle_check("8n2_ok", 0);
  endtask

  task automatic test_false_start;
    cfg_stop2 = 1'b0;
    @(negedge clk); rx = 1'b0;
    repeat (8) @(negedge clk); rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    idle_check("false_start", 0);
    exp_data.push_back(8'h96);
    send_frame(8'h96, 8, 0, 0, 0, 1);
    idle_check("after_false", 0);
  endtask

  task automatic test_overrun;
    ready_out = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_data.push_back(8'(i));
      else        exp_err.push_back(3'b100);
      send_frame(8'(i), 8, 0, 0, 0, 1);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (fifo_level !== 4'd8) begin n_bad++; $display("FAIL ovr_full_level got %0d expected 8", fifo_level); end
    n_cmp++;
    if (exp_err.size() !== 0) begin n_bad++; $display("FAIL ovr_error_seen got %0d pending expected 0", exp_err.size()); end
    ready_out = 1'b1;
    idle_check("ovr_drain", 0);
  endtask

  task automatic test_reset_midframe;
    @(negedge clk); rx = 1'b0; repeat (BIT) @(negedge clk);
    for (int i = 0; i < 3; i++) begin rx = i[0]; repeat (BIT) @(negedge clk); end
    rst_n = 1'b0; rx = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp += 4;
    if (dout !== 8'h00)                 begin n_bad++; $display("FAIL mid_rst_out got %h expected 00", dout); end
    if (valid_out !== 1'b0)             begin n_bad++; $display("FAIL mid_rst_valid got %b expected 0", valid_out); end
    if (error !== 3'b000)               begin n_bad++; $display("FAIL mid_rst_error got %b expected 000", error); end
    if (fifo_level !== 4'd0)            begin n_bad++; $display("FAIL mid_rst_level got %0d expected 0", fifo_level); end
    rst_n = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    exp_data.push_back(8'h5A);
    send_frame(8'h5A, 8, 0, 0, 0, 1);
    idle_check("after_rst", 0);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_framing();
    test_false_start();
    test_overrun();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
